// File: rtl/pmem_arbiter_if.sv
// Program-memory read-port bundle: fetch and load requesters, plus the memory address/data pair.
// The master side drives requests and the memory word; the slave side is the arbiter.
interface pmem_arbiter_if #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_flush;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [WORD_WIDTH-1:0] if_rdata;
   logic                  ld_req;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic                  ld_gnt;
   logic                  ld_rvalid;
   logic [WORD_WIDTH-1:0] ld_rdata;
   logic [ADDR_WIDTH-1:0] pmem_addr;
   logic [WORD_WIDTH-1:0] pmem_word;

   modport master (
      output if_req, if_addr, if_flush, ld_req, ld_addr, pmem_word,
      input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, pmem_addr
   );

   modport slave (
      input  if_req, if_addr, if_flush, ld_req, ld_addr, pmem_word,
      output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, pmem_addr
   );
endinterface

// File: rtl/pmem_arbiter.sv
// Fetch/load arbiter for the program-memory read port; grant is combinational, data returns 1 cycle later.
// No stall path: a denied requester holds its request, and a starving load is forced through after STARVE_LIMIT denials.
module pmem_arbiter #(
   parameter int WORD_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 12,
   parameter int STARVE_LIMIT = 3
) (
   input logic           clock,
   input logic           reset,
   pmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_IF   = 2'd1,
      OWNER_LD   = 2'd2
   } owner_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   owner_t                owner_q, owner_d;
   logic [3:0]            starve_cnt_q, starve_cnt_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
   logic                  grant_if, grant_ld;
   logic                  if_rvalid, ld_rvalid;

   always_ff @(posedge clock) begin
      if (reset) begin
         owner_q      <= OWNER_NONE;
         starve_cnt_q <= 4'd0;
         last_addr_q  <= '0;
      end else begin
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         last_addr_q  <= last_addr_d;
      end
   end

   always_comb begin
      grant_if     = 1'b0;
      grant_ld     = 1'b0;
      owner_d      = OWNER_NONE;
      starve_cnt_d = starve_cnt_q;
      last_addr_d  = last_addr_q;
      // A flush frees the cycle, so a pending load takes it even without starvation.
      if (!reset) begin
         if (bus.ld_req && (starve_cnt_q == LIMIT || !bus.if_req || bus.if_flush)) begin
            grant_ld    = 1'b1;
            owner_d     = OWNER_LD;
            last_addr_d = bus.ld_addr;
         end else if (bus.if_req && !bus.if_flush) begin
            grant_if    = 1'b1;
            owner_d     = OWNER_IF;
            last_addr_d = bus.if_addr;
         end
      end
      if (grant_ld || !bus.ld_req) begin
         starve_cnt_d = 4'd0;
      end else if (starve_cnt_q < LIMIT) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   assign if_rvalid = !reset && (owner_q == OWNER_IF) && !bus.if_flush;
   assign ld_rvalid = !reset && (owner_q == OWNER_LD);

   // Holding last_addr while idle keeps the memory output stable.
   assign bus.pmem_addr = grant_ld ? bus.ld_addr : (grant_if ? bus.if_addr : last_addr_q);
   assign bus.if_gnt    = grant_if;
   assign bus.ld_gnt    = grant_ld;
   assign bus.if_rvalid = if_rvalid;
   assign bus.ld_rvalid = ld_rvalid;
   assign bus.if_rdata  = if_rvalid ? bus.pmem_word : '0;
   assign bus.ld_rdata  = ld_rvalid ? bus.pmem_word : '0;

   a_exclusive : assert property (@(posedge clock)
      !(grant_if && grant_ld) && !(if_rvalid && ld_rvalid));
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
// The memory is an array behind a one-cycle registered read of pmem_addr.
module tb_pmem_arbiter;
   localparam int WW    = 16;
   localparam int AW    = 12;
   localparam int LIMIT = 3;

   logic clock;
   logic reset;
   int   checks = 0;
   int   passes = 0;

   logic [WW-1:0] mem [0:2047];

   pmem_arbiter_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

   pmem_arbiter #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) bus.pmem_word <= mem[bus.pmem_addr[AW-1:1]];

   // Model: who was granted last cycle, how long the current load has been denied, last granted address.
   int            m_pend = 0;
   logic [AW-1:0] m_pend_addr = '0;
   int            m_wait = 0;
   logic [AW-1:0] m_last = '0;
   logic          p_rst = 1'b1, p_ld_win = 1'b0, p_if_win = 1'b0, p_ldr = 1'b0;
   logic [AW-1:0] p_ifa = '0, p_lda = '0;
   logic          e_if_gnt, e_ld_gnt, e_if_rv, e_ld_rv;
   logic [WW-1:0] e_if_rd, e_ld_rd;
   logic [AW-1:0] e_paddr;

   task automatic drive(input logic rst, input logic ifr, input logic [AW-1:0] ifa,
                        input logic fl, input logic ldr, input logic [AW-1:0] lda);
      logic ld_win, if_win;
      @(negedge clock);
      if (p_rst) begin
         m_pend = 0;
         m_wait = 0;
         m_last = '0;
      end else begin
         m_pend      = p_ld_win ? 2 : (p_if_win ? 1 : 0);
         m_pend_addr = p_ld_win ? p_lda : p_ifa;
         if (m_pend != 0) m_last = m_pend_addr;
         m_wait = (p_ld_win || !p_ldr) ? 0 : m_wait + 1;
      end
      reset        = rst;
      bus.if_req   = ifr;
      bus.if_addr  = ifa;
      bus.if_flush = fl;
      bus.ld_req   = ldr;
      bus.ld_addr  = lda;
      ld_win   = !rst && ldr && (m_wait >= LIMIT || !ifr || fl);
      if_win   = !rst && ifr && !fl && !ld_win;
      e_if_gnt = if_win;
      e_ld_gnt = ld_win;
      e_paddr  = ld_win ? lda : (if_win ? ifa : m_last);
      e_if_rv  = !rst && (m_pend == 1) && !fl;
      e_ld_rv  = !rst && (m_pend == 2);
      e_if_rd  = e_if_rv ? mem[m_pend_addr[AW-1:1]] : '0;
      e_ld_rd  = e_ld_rv ? mem[m_pend_addr[AW-1:1]] : '0;
      p_rst = rst; p_ld_win = ld_win; p_if_win = if_win; p_ldr = ldr; p_ifa = ifa; p_lda = lda;
      #1;
   endtask

   task automatic test_reset();
      drive(1, 1, 12'h040, 0, 1, 12'h080);
      checks++; if (bus.if_gnt !== 1'b0) $display("FAIL reset_if_gnt: got %b want 0", bus.if_gnt); else passes++;
      checks++; if (bus.ld_gnt !== 1'b0) $display("FAIL reset_ld_gnt: got %b want 0", bus.ld_gnt); else passes++;
      checks++; if (bus.pmem_addr !== 12'h000) $display("FAIL reset_pmem_addr: got %h want 000", bus.pmem_addr); else passes++;
      drive(0, 0, 0, 0, 0, 0);
      checks++; if ({bus.if_rvalid, bus.ld_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", {bus.if_rvalid, bus.ld_rvalid}); else passes++;
      checks++; if ({bus.if_rdata, bus.ld_rdata} !== 32'h0) $display("FAIL reset_rdata: got %h want 0", {bus.if_rdata, bus.ld_rdata}); else passes++;
      checks++; if (bus.pmem_addr !== 12'h000) $display("FAIL release_pmem_addr: got %h want 000", bus.pmem_addr); else passes++;
   endtask

   task automatic test_fetch_only();
      for (int c = 0; c < 4; c++) begin
         if (c < 3) drive(0, 1, 12'(2 * c), 0, 0, 0);
         else       drive(0, 0, 0, 0, 0, 0);
         if (c < 3) begin
            checks++; if (bus.if_gnt !== 1'b1) $display("FAIL fetch_gnt c%0d: got %b want 1", c, bus.if_gnt); else passes++;
         end
         if (c > 0) begin
            checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== mem[c - 1])
               $display("FAIL fetch_rdata c%0d: got %b/%h want 1/%h", c, bus.if_rvalid, bus.if_rdata, mem[c - 1]); else passes++;
         end
         checks++; if (bus.ld_rvalid !== 1'b0) $display("FAIL fetch_ld_rvalid c%0d: got %b want 0", c, bus.ld_rvalid); else passes++;
      end
   endtask

   task automatic test_starvation();
      for (int c = 0; c <= LIMIT; c++) begin
         drive(0, 1, 12'(12'h020 + 2 * c), 0, 1, 12'h100);
         checks++; if (bus.ld_gnt !== (c == LIMIT)) $display("FAIL starve_ld_gnt c%0d: got %b want %b", c, bus.ld_gnt, c == LIMIT); else passes++;
         checks++; if (bus.if_gnt !== (c != LIMIT)) $display("FAIL starve_if_gnt c%0d: got %b want %b", c, bus.if_gnt, c != LIMIT); else passes++;
      end
      drive(0, 1, 12'h026, 0, 0, 0);
      checks++; if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== mem[12'h080])
         $display("FAIL starve_ld_rdata: got %b/%h want 1/%h", bus.ld_rvalid, bus.ld_rdata, mem[12'h080]); else passes++;
      checks++; if (bus.if_gnt !== 1'b1) $display("FAIL starve_if_resume: got %b want 1", bus.if_gnt); else passes++;
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_idle_fetch();
      drive(0, 0, 0, 0, 1, 12'h0A6);
      checks++; if (bus.ld_gnt !== 1'b1) $display("FAIL idle_ld_gnt: got %b want 1", bus.ld_gnt); else passes++;
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== mem[12'h053])
         $display("FAIL idle_ld_rdata: got %b/%h want 1/%h", bus.ld_rvalid, bus.ld_rdata, mem[12'h053]); else passes++;
      checks++; if (bus.pmem_addr !== 12'h0A6) $display("FAIL idle_hold_addr: got %h want 0a6", bus.pmem_addr); else passes++;
   endtask

   task automatic test_flush();
      drive(0, 1, 12'h010, 0, 0, 0);
      checks++; if (bus.if_gnt !== 1'b1) $display("FAIL flush_pre_gnt: got %b want 1", bus.if_gnt); else passes++;
      drive(0, 1, 12'h012, 1, 1, 12'h200);
      checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== '0)
         $display("FAIL flush_mask: got %b/%h want 0/0000", bus.if_rvalid, bus.if_rdata); else passes++;
      checks++; if ({bus.if_gnt, bus.ld_gnt} !== 2'b01) $display("FAIL flush_gnt: got %b want 01", {bus.if_gnt, bus.ld_gnt}); else passes++;
      checks++; if (bus.pmem_addr !== 12'h200) $display("FAIL flush_pmem_addr: got %h want 200", bus.pmem_addr); else passes++;
      drive(0, 1, 12'h012, 0, 0, 0);
      checks++; if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== mem[12'h100])
         $display("FAIL flush_ld_rdata: got %b/%h want 1/%h", bus.ld_rvalid, bus.ld_rdata, mem[12'h100]); else passes++;
      checks++; if (bus.if_gnt !== 1'b1) $display("FAIL flush_if_regrant: got %b want 1", bus.if_gnt); else passes++;
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== mem[12'h009])
         $display("FAIL flush_if_rdata: got %b/%h want 1/%h", bus.if_rvalid, bus.if_rdata, mem[12'h009]); else passes++;
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 0, 0, 1, 12'h300);
      checks++; if (bus.ld_gnt !== 1'b1) $display("FAIL rstmid_ld_gnt: got %b want 1", bus.ld_gnt); else passes++;
      drive(1, 1, 12'h050, 0, 1, 12'h302);
      checks++; if (bus.ld_rvalid !== 1'b0) $display("FAIL rstmid_ld_rvalid_n: got %b want 0", bus.ld_rvalid); else passes++;
      checks++; if (bus.pmem_addr !== 12'h300) $display("FAIL rstmid_pmem_addr_n: got %h want 300", bus.pmem_addr); else passes++;
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.ld_rvalid !== 1'b0) $display("FAIL rstmid_ld_rvalid_n1: got %b want 0", bus.ld_rvalid); else passes++;
      checks++; if (bus.pmem_addr !== 12'h000) $display("FAIL rstmid_pmem_addr_n1: got %h want 000", bus.pmem_addr); else passes++;
      // Build up starvation, reset, then the load must wait the full limit again.
      drive(0, 1, 12'h060, 0, 1, 12'h310);
      drive(0, 1, 12'h062, 0, 1, 12'h310);
      drive(1, 1, 12'h064, 0, 1, 12'h310);
      for (int c = 0; c <= LIMIT; c++) begin
         drive(0, 1, 12'(12'h064 + 2 * c), 0, 1, 12'h310);
         checks++; if (bus.ld_gnt !== (c == LIMIT)) $display("FAIL rst_starve_clear c%0d: got %b want %b", c, bus.ld_gnt, c == LIMIT); else passes++;
         if (c == 0) begin
            checks++; if ({bus.if_gnt, bus.ld_gnt} !== 2'b10) $display("FAIL simultaneous_gnt: got %b want 10", {bus.if_gnt, bus.ld_gnt}); else passes++;
         end
      end
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic          ifr = 1'b0, ldr = 1'b0, fl, rst;
      logic [AW-1:0] ifa = '0, lda = '0;
      for (int c = 0; c < 400; c++) begin
         if (!ifr && $urandom_range(0, 3) != 0) begin ifr = 1'b1; ifa = AW'($urandom) & 12'hFFE; end
         if (!ldr && $urandom_range(0, 2) == 0) begin ldr = 1'b1; lda = AW'($urandom) & 12'hFFE; end
         fl  = ($urandom_range(0, 6) == 0);
         rst = ($urandom_range(0, 49) == 0);
         drive(rst, ifr, ifa, fl, ldr, lda);
         checks++; if (bus.if_gnt !== e_if_gnt) $display("FAIL rnd_if_gnt c%0d: got %b want %b", c, bus.if_gnt, e_if_gnt); else passes++;
         checks++; if (bus.ld_gnt !== e_ld_gnt) $display("FAIL rnd_ld_gnt c%0d: got %b want %b", c, bus.ld_gnt, e_ld_gnt); else passes++;
         checks++; if (bus.pmem_addr !== e_paddr) $display("FAIL rnd_pmem_addr c%0d: got %h want %h", c, bus.pmem_addr, e_paddr); else passes++;
         checks++; if (bus.if_rvalid !== e_if_rv) $display("FAIL rnd_if_rvalid c%0d: got %b want %b", c, bus.if_rvalid, e_if_rv); else passes++;
         checks++; if (bus.ld_rvalid !== e_ld_rv) $display("FAIL rnd_ld_rvalid c%0d: got %b want %b", c, bus.ld_rvalid, e_ld_rv); else passes++;
         checks++; if (bus.if_rdata !== e_if_rd) $display("FAIL rnd_if_rdata c%0d: got %h want %h", c, bus.if_rdata, e_if_rd); else passes++;
         checks++; if (bus.ld_rdata !== e_ld_rd) $display("FAIL rnd_ld_rdata c%0d: got %h want %h", c, bus.ld_rdata, e_ld_rd); else passes++;
         checks++; if ((bus.if_gnt && bus.ld_gnt) || (bus.if_rvalid && bus.ld_rvalid))
            $display("FAIL rnd_exclusive c%0d: got gnt %b%b rvalid %b%b want no pair", c, bus.if_gnt, bus.ld_gnt, bus.if_rvalid, bus.ld_rvalid); else passes++;
         if (e_if_gnt) ifr = 1'b0;
         if (e_ld_gnt) ldr = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = WW'($urandom);
      reset        = 1'b1;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.if_flush = 1'b0;
      bus.ld_req   = 1'b0;
      bus.ld_addr  = '0;
      test_reset();
      test_fetch_only();
      test_starvation();
      test_idle_fetch();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
